svi_chan_skid_array: RTL and testbench
======================================

Name: svi_chan_skid_array

Overview:
- Parametrised successor to the single-bit SVI latch stage.
- An array of NCH independent channels, each a WIDTH-bit, 2-entry valid/ready skid buffer.
- Each channel connects upstream and downstream through an array of SystemVerilog interface (SVI) instances, using modports.
- Replaces latch-based capture with flop-based, backpressure-aware buffering; sits between SVI producer and consumer module arrays.

Parameters:
- NCH, 8, number of channels (SVI array size), >=1.
- WIDTH, 1, data bits per channel, >=1.
- CNT_W, 8, width of per-channel transfer counter (used only with SVI_CHAN_CNT_EN).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_srst  input  1  reset, synchronous, active-high.
- en  input  1  global accept enable; low blocks new upstream transfers on all channels.
- up[NCH-1:0]  interface  svi_chan.P_IN  upstream side; block drives ready, samples data/valid.
- dn[NCH-1:0]  interface  svi_chan.P_OUT  downstream side; block drives data/valid, samples ready.
- o_full  output  NCH  bit i = channel i holds 2 entries.
- o_empty  output  NCH  bit i = channel i holds 0 entries.
- Interface svi_chan #(WIDTH) members: data[WIDTH], valid, ready.
- Modport P_IN: input data, valid; output ready.
- Modport P_OUT: output data, valid; input ready.

Behaviour:
- Reset (i_srst=1 at an edge), every channel:
  - state=EMPTY; main and skid data = 0; counters = 0.
  - While i_srst is high, up[i].ready=0 and dn[i].valid=0.
  - Reset mid-transfer discards both entries; no flush.
- Per channel, states EMPTY(0), ONE(1), TWO(2) held in a flop.
- Outputs:
  - dn.valid = (state!=EMPTY).
  - dn.data = main.
  - up.ready = en & (state!=TWO) & ~i_srst.
- Transfers:
  - in = up.valid & up.ready.
  - out = dn.valid & dn.ready.
- Transitions:
  - EMPTY: in -> ONE, main<=up.data. Otherwise stay.
  - ONE, in & ~out -> TWO, skid<=up.data.
  - ONE, in & out -> ONE, main<=up.data.
  - ONE, ~in & out -> EMPTY.
  - ONE, neither -> stay.
  - TWO: out -> ONE, main<=skid. Otherwise stay. "in" is impossible because ready=0.
- Latency: up accept at edge N -> dn.valid high after edge N (visible cycle N+1).
- No combinational path from up to dn data/valid.
- Throughput: 1 transfer/cycle per channel while dn.ready=1; no bubbles.
- Ordering: strict FIFO per channel.
- Channels are fully independent; one channel's backpressure never affects another.
- en=0: no new accepts; buffered entries keep draining normally; state otherwise held.
- en toggling mid-burst loses no data.
- o_full[i] = (state==TWO); o_empty[i] = (state==EMPTY).
- Both are registered-state decodes; 0 and 1 respectively after reset.
- Data entries are held unchanged while not written.
- dn.data is stable while dn.valid=1 and dn.ready=0.

Optional Feature:
- Macro SVI_CHAN_CNT_EN.
- Defined:
  - Adds output port o_cnt [NCH*CNT_W], where slice i = count of dn transfers on channel i.
  - Increments by 1 per out; wraps modulo 2^CNT_W (255 -> 0 at default).
  - Reset to 0 by i_srst.
- Undefined: port and counters absent; no other behaviour change.

Decomposition:
- Package svi_chan_pkg:
  - typedef state_t enum logic[1:0] {EMPTY, ONE, TWO}.
  - Localparam defaults for NCH, WIDTH, CNT_W.
- Interface svi_chan lives in its own file (interfaces cannot live in a package).
- Sub-module svi_chan_skid: one channel, scalar data/valid/ready ports.
  - Instantiated NCH times in a generate loop indexing up[i]/dn[i].

Test Plan:
- Reset: hold i_srst 3 cycles with up.valid=1 -> ready=0, dn.valid=0, o_empty=8'hFF, o_full=0, o_cnt=0.
- Streaming, WIDTH=8, ch0: send 0x11,0x22,0x33 with dn.ready=1 -> dn.data 0x11,0x22,0x33 on consecutive cycles, each one cycle after accept; o_full[0] never set.
- Backpressure, ch3: dn.ready=0, send 0xA5, 0x5A:
  - After 2 accepts, o_full[3]=1 and up[3].ready=0.
  - Release ready -> 0xA5 then 0x5A; other channels unaffected.
- en gating: TWO state, en=0, dn.ready=1 -> both entries drain, ready stays 0; en=1 -> accepts resume next cycle.
- Reset mid-operation: channels in ONE/TWO, pulse i_srst 1 cycle -> all EMPTY next cycle, previous data never appears on dn.
- SVI_CHAN_CNT_EN, CNT_W=8: 257 transfers on ch1 -> o_cnt slice1=1; slices for idle channels stay 0.

Source files
------------

// File: rtl/svi_chan_pkg.sv
// svi_chan_pkg: shared types and parameter defaults for the SVI skid-buffer array.
//   state_t   - per-channel occupancy state (EMPTY / ONE / TWO entries held)
//   *_DEF     - default values for NCH, WIDTH and CNT_W
package svi_chan_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int NCH_DEF   = 8;
  localparam int WIDTH_DEF = 1;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/svi_chan.sv
// svi_chan: one valid/ready channel carrying WIDTH data bits.
//   data  - payload, driven by the producer
//   valid - producer has a beat on data
//   ready - consumer accepts the beat this cycle
//   P_IN  - consumer-side view (block receives data, drives ready)
//   P_OUT - producer-side view (block drives data, samples ready)
interface svi_chan #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport P_IN  (input data, input valid, output ready);
  modport P_OUT (output data, output valid, input ready);
endinterface

// File: rtl/svi_chan_skid.sv
// svi_chan_skid: one channel, 2-entry flop-based valid/ready skid buffer.
//   clk_i, srst_i         - clock, synchronous active-high reset
//   en_i                  - accept enable (low blocks new upstream beats)
//   up_data_i/valid_i     - upstream beat; up_ready_o back to producer
//   dn_data_o/valid_o     - downstream beat; dn_ready_i from consumer
//   full_o / empty_o      - occupancy decodes of the registered state
//   cnt_o                 - downstream transfer count (SVI_CHAN_CNT_EN only)
module svi_chan_skid
  import svi_chan_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  output logic [WIDTH-1:0] dn_data_o,
  output logic             dn_valid_o,
  input  logic             dn_ready_i,
`ifdef SVI_CHAN_CNT_EN
  output logic [CNT_W-1:0] cnt_o,
`endif
  output logic             full_o,
  output logic             empty_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             xfer_in, xfer_out;

  // dn.valid is also masked by reset so the output is quiet even before the
  // first reset edge has cleared the state flop.
  assign up_ready_o = en_i & (state_q != TWO) & ~srst_i;
  assign dn_valid_o = (state_q != EMPTY) & ~srst_i;
  assign dn_data_o  = main_q;
  assign full_o     = (state_q == TWO);
  assign empty_o    = (state_q == EMPTY);

  assign xfer_in  = up_valid_i & up_ready_o;
  assign xfer_out = dn_valid_o & dn_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (xfer_in) begin
          state_d = ONE;
          main_d  = up_data_i;
        end
      end
      ONE: begin
        if (xfer_in && !xfer_out) begin
          state_d = TWO;
          skid_d  = up_data_i;
        end else if (xfer_in && xfer_out) begin
          main_d  = up_data_i;
        end else if (xfer_out) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // up_ready is low here, so only a drain can happen
        if (xfer_out) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef SVI_CHAN_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // wraps naturally at 2^CNT_W
  always_ff @(posedge clk_i) begin
    if (srst_i)        cnt_q <= '0;
    else if (xfer_out) cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/svi_chan_skid_array.sv
// svi_chan_skid_array: NCH independent 2-entry skid buffers between SVI arrays.
//   i_clk, i_srst - clock, synchronous active-high reset
//   en            - global accept enable for all channels
//   up[NCH]       - upstream SVI channels (P_IN)
//   dn[NCH]       - downstream SVI channels (P_OUT)
//   o_full        - bit i set when channel i holds 2 entries
//   o_empty       - bit i set when channel i holds 0 entries
//   o_cnt         - NCH x CNT_W transfer counters, present only when the
//                   SVI_CHAN_CNT_EN macro is defined
module svi_chan_skid_array
  import svi_chan_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_srst,
  input  logic               en,
  svi_chan.P_IN              up [NCH-1:0],
  svi_chan.P_OUT             dn [NCH-1:0],
`ifdef SVI_CHAN_CNT_EN
  output logic [NCH*CNT_W-1:0] o_cnt,
`endif
  output logic [NCH-1:0]     o_full,
  output logic [NCH-1:0]     o_empty
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    svi_chan_skid #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_i      (i_clk),
      .srst_i     (i_srst),
      .en_i       (en),
      .up_data_i  (up[i].data),
      .up_valid_i (up[i].valid),
      .up_ready_o (up[i].ready),
      .dn_data_o  (dn[i].data),
      .dn_valid_o (dn[i].valid),
      .dn_ready_i (dn[i].ready),
`ifdef SVI_CHAN_CNT_EN
      .cnt_o      (o_cnt[i*CNT_W +: CNT_W]),
`endif
      .full_o     (o_full[i]),
      .empty_o    (o_empty[i])
    );
  end

endmodule

// File: tb/tb_svi_chan_skid_array.sv
// tb_svi_chan_skid_array: randomized + directed bench against a per-channel
// queue model. Counter checks are compiled in with SVI_CHAN_CNT_EN.
module tb_svi_chan_skid_array;
  localparam int NCH   = 8;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic                       rst, ena;
  logic [NCH-1:0]             up_valid, up_ready, dn_valid, dn_ready;
  logic [NCH-1:0][WIDTH-1:0]  up_data, dn_data;
  logic [NCH-1:0]             o_full, o_empty;
`ifdef SVI_CHAN_CNT_EN
  logic [NCH*CNT_W-1:0]       o_cnt;
`endif

  svi_chan #(.WIDTH(WIDTH)) up_if [NCH-1:0] ();
  svi_chan #(.WIDTH(WIDTH)) dn_if [NCH-1:0] ();

  for (genvar g = 0; g < NCH; g++) begin : g_tie
    assign up_if[g].data  = up_data[g];
    assign up_if[g].valid = up_valid[g];
    assign up_ready[g]    = up_if[g].ready;
    assign dn_data[g]     = dn_if[g].data;
    assign dn_valid[g]    = dn_if[g].valid;
    assign dn_if[g].ready = dn_ready[g];
  end

  svi_chan_skid_array #(.NCH(NCH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk   (i_clk),
    .i_srst  (rst),
    .en      (ena),
    .up      (up_if),
    .dn      (dn_if),
`ifdef SVI_CHAN_CNT_EN
    .o_cnt   (o_cnt),
`endif
    .o_full  (o_full),
    .o_empty (o_empty)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: each channel is a FIFO of at most two beats plus a transfer count.
  logic [WIDTH-1:0] q [NCH][$];
  int               cnt [NCH];

  // One cycle: drive at negedge, check against the model, then advance the
  // model on the rising edge with the pre-edge handshake.
  task automatic cycle(input logic r, input logic e, input logic [NCH-1:0] v,
                       input logic [NCH-1:0][WIDTH-1:0] d, input logic [NCH-1:0] rdy);
    logic [NCH-1:0] exp_rdy;
    @(negedge i_clk);
    rst = r; ena = e; up_valid = v; up_data = d; dn_ready = rdy;
    #1;
    for (int i = 0; i < NCH; i++) begin
      exp_rdy[i] = e && !r && (q[i].size() < 2);
      chk($sformatf("ready[%0d]", i), 32'(up_ready[i]), 32'(exp_rdy[i]));
      chk($sformatf("valid[%0d]", i), 32'(dn_valid[i]), 32'(!r && q[i].size() > 0));
      if (!r && q[i].size() > 0)
        chk($sformatf("data[%0d]", i), 32'(dn_data[i]), 32'(q[i][0]));
      chk($sformatf("full[%0d]", i), 32'(o_full[i]), 32'(q[i].size() == 2));
      chk($sformatf("empty[%0d]", i), 32'(o_empty[i]), 32'(q[i].size() == 0));
`ifdef SVI_CHAN_CNT_EN
      chk($sformatf("cnt[%0d]", i), 32'(o_cnt[i*CNT_W +: CNT_W]), 32'(cnt[i]));
`endif
    end
    @(posedge i_clk);
    for (int i = 0; i < NCH; i++) begin
      if (r) begin
        q[i].delete();
        cnt[i] = 0;
      end else begin
        if (q[i].size() > 0 && rdy[i]) begin
          void'(q[i].pop_front());
          cnt[i] = (cnt[i] + 1) % (1 << CNT_W);
        end
        if (v[i] && exp_rdy[i]) q[i].push_back(d[i]);
      end
    end
  endtask

  logic [NCH-1:0][WIDTH-1:0] dz, dr;
  int                        prdy;

  initial begin
    dz = '0;
    rst = 1'b1; ena = 1'b1; up_valid = '1; up_data = '0; dn_ready = '0;
    @(posedge i_clk);                      // model starts in the reset state
    repeat (3) cycle(1'b1, 1'b1, '1, '1, '1);

    // streaming on ch0: 11, 22, 33 then drain
    dr = dz; dr[0] = 8'h11; cycle(1'b0, 1'b1, 8'h01, dr, '1);
    dr[0] = 8'h22;          cycle(1'b0, 1'b1, 8'h01, dr, '1);
    dr[0] = 8'h33;          cycle(1'b0, 1'b1, 8'h01, dr, '1);
    repeat (2)              cycle(1'b0, 1'b1, '0, dz, '1);

    // backpressure on ch3, then release; ch0 streams meanwhile
    dr = dz; dr[3] = 8'hA5; dr[0] = 8'h01; cycle(1'b0, 1'b1, 8'h09, dr, 8'hF7);
    dr[3] = 8'h5A; dr[0] = 8'h02;          cycle(1'b0, 1'b1, 8'h09, dr, 8'hF7);
    dr[3] = 8'hFF; dr[0] = 8'h03;          cycle(1'b0, 1'b1, 8'h09, dr, 8'hF7);
    repeat (3)                              cycle(1'b0, 1'b1, '0, dz, '1);

    // en gating: fill ch2 to TWO, drain with en low, then resume
    dr = dz; dr[2] = 8'h77; cycle(1'b0, 1'b1, 8'h04, dr, '0);
    dr[2] = 8'h88;          cycle(1'b0, 1'b1, 8'h04, dr, '0);
    dr[2] = 8'h99; repeat (3) cycle(1'b0, 1'b0, 8'h04, dr, '1);
    repeat (2)     cycle(1'b0, 1'b1, 8'h04, dr, '1);

    // reset mid-operation with channels in ONE/TWO
    dr = dz; for (int i = 0; i < NCH; i++) dr[i] = 8'(8'hC0 + i);
    cycle(1'b0, 1'b1, '1, dr, '0);
    cycle(1'b0, 1'b1, 8'h0F, dr, '0);
    cycle(1'b1, 1'b1, '1, dr, '1);
    repeat (2) cycle(1'b0, 1'b1, '0, dz, '1);

    // randomized traffic, varying backpressure density
    for (int ph = 0; ph < 4; ph++) begin
      prdy = 20 + ph * 25;
      for (int c = 0; c < 150; c++) begin
        logic [NCH-1:0] v, rd;
        for (int i = 0; i < NCH; i++) begin
          dr[i] = 8'($urandom);
          v[i]  = ($urandom_range(0, 99) < 60);
          rd[i] = ($urandom_range(0, 99) < prdy);
        end
        cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0), v, dr, rd);
      end
    end

    // 257 back-to-back transfers on ch1 from a clean reset
    cycle(1'b1, 1'b1, '0, dz, '1);
    for (int c = 0; c < 257; c++) begin
      dr = dz; dr[1] = 8'(c);
      cycle(1'b0, 1'b1, 8'h02, dr, '1);
    end
    repeat (2) cycle(1'b0, 1'b1, '0, dz, '1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
